ark_round_256: RTL and testbench

Registered AddRoundKey stage for the 256-bit-block Rijndael datapath, sitting directly downstream of the 256-bit MixColumns stage. It XORs each incoming 256-bit state with the round key selected by an internal round counter, and holds the 15 round keys (rounds 0..14) in a locally written key store. One beat is accepted per round, and the output is one registered beat with a valid/ready handshake.

---
 rtl/ark_round_256_pkg.sv | 25 ++
 rtl/ark_round_256_key_store.sv | 31 +++
 rtl/ark_round_256.sv | 114 +++++++++++
 tb/tb_ark_round_256.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ark_round_256_pkg.sv
// Shared types and constants for the 256-bit AddRoundKey stage.
package ark_round_256_pkg;

    localparam int NR_DEF = 14;
    localparam int CW_DEF = 4;
    localparam int SW     = 256;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Column c sits at [255-32c : 224-32c]; row 0 is the column MSB.
    function automatic logic [31:0] col_get(input logic [SW-1:0] s,
                                            input int c);
        return s[SW-1-32*c -: 32];
    endfunction

    function automatic logic [7:0] byte_get(input logic [SW-1:0] s,
                                            input int c,
                                            input int r);
        return s[SW-1-32*c-8*r -: 8];
    endfunction

endpackage

// File: rtl/ark_round_256_key_store.sv
// Round-key register file: synchronous write, asynchronous read.
module ark_key_store
    import ark_round_256_pkg::*;
#(
    parameter int NR = NR_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [CW-1:0] waddr_i,
    input  logic [SW-1:0] wdata_i,
    input  logic [CW-1:0] raddr_i,
    output logic [SW-1:0] rdata_o
);

    logic [SW-1:0] mem_q [NR+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ark_round_256.sv
// Registered AddRoundKey stage: state XOR key[round], valid/ready output.
module ark_round_256
    import ark_round_256_pkg::*;
#(
    parameter int NR = NR_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_we,
    input  logic [CW-1:0] key_addr,
    input  logic [SW-1:0] key_wdata,
    output logic          key_err,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_state,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_state,
    output logic [CW-1:0] out_round,
    output logic          out_last
);

    localparam logic [CW-1:0] LAST = CW'(NR);

    state_e        state_q, state_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic          vld_q, vld_d;
    logic [SW-1:0] st_q, st_d;
    logic [CW-1:0] rnd_q, rnd_d;
    logic          last_q, last_d;
    logic          err_q, err_d;

    logic          accept;
    logic          key_ok;
    logic [CW-1:0] rd_round;
    logic [SW-1:0] key_rd;

    ark_key_store #(
        .NR(NR),
        .CW(CW)
    ) u_keys (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (key_ok),
        .waddr_i (key_addr),
        .wdata_i (key_wdata),
        .raddr_i (rd_round),
        .rdata_o (key_rd)
    );

    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready;
    // start restarts the counter for a beat accepted in the same cycle
    assign rd_round = start ? '0 : ctr_q;
    assign key_ok   = key_we && (state_q == IDLE) && (key_addr <= LAST);

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        vld_d   = vld_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        last_d  = last_q;
        err_d   = key_we && !key_ok;
        if (start) begin
            state_d = IDLE;
            ctr_d   = '0;
        end
        if (accept) begin
            vld_d  = 1'b1;
            st_d   = in_state ^ key_rd;
            rnd_d  = rd_round;
            last_d = (rd_round == LAST);
            if (rd_round == LAST) begin
                state_d = IDLE;
                ctr_d   = '0;
            end else begin
                state_d = RUN;
                ctr_d   = rd_round + 1'b1;
            end
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            vld_q   <= 1'b0;
            st_q    <= '0;
            rnd_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            vld_q   <= vld_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = vld_q;
    assign out_state = st_q;
    assign out_round = rnd_q;
    assign out_last  = last_q;
    assign key_err   = err_q;

endmodule

// File: tb/tb_ark_round_256.sv
// Scoreboard bench for ark_round_256 using directed vectors.
module tb_ark_round_256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_we;
    logic [3:0]   key_addr;
    logic [255:0] key_wdata;
    logic         key_err;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;

    typedef struct packed {
        logic [255:0] st;
        logic [3:0]   rnd;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ark_round_256 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_we    (key_we),
        .key_addr  (key_addr),
        .key_wdata (key_wdata),
        .key_err   (key_err),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_round (out_round),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] kval(input int r);
        logic [7:0] b;
        b = r[7:0];
        return {32{b}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got round %0d want none",
                         out_round);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_state", out_state, e.st);
                chk("out_round", 256'(out_round), 256'(e.rnd));
                chk("out_last", 256'(out_last), 256'(e.last));
            end
        end
    end

    task automatic send(input logic [255:0] st, input logic [255:0] ex,
                        input int rnd, input bit with_start);
        int budget;
        exp_t e;
        budget = 50;
        in_state = st;
        in_valid = 1'b1;
        start = with_start;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready 0 want 1");
        end else begin
            e.st = ex;
            e.rnd = rnd[3:0];
            e.last = (rnd == 14);
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wkey(input int a, input logic [255:0] d);
        key_we = 1'b1;
        key_addr = a[3:0];
        key_wdata = d;
        @(posedge clk); #1;
        key_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    localparam logic [255:0] ONES = '1;
    localparam logic [255:0] PAT_P = {8{32'hA5C3_1E70}};
    localparam logic [255:0] PAT_Q = {8{32'h1234_5678}};
    localparam logic [255:0] PAT_X = {8{32'h0F0F_F0F0}};
    localparam logic [255:0] PAT_A = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] PAT_B = {8{32'hCAFE_F00D}};
    localparam logic [255:0] PAT_C = {8{32'h0102_0304}};
    localparam logic [255:0] PAT_D = {8{32'h8899_AABB}};

    initial begin
        int budget;
        exp_t e;
        rst_n = 1'b0;
        key_we = 1'b0;
        key_addr = '0;
        key_wdata = '0;
        start = 1'b0;
        in_valid = 1'b0;
        in_state = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_out_state", out_state, 256'd0);
        chk("rst_out_round", 256'(out_round), 256'd0);
        chk("rst_out_last", 256'(out_last), 256'd0);
        chk("rst_key_err", 256'(key_err), 256'd0);
        chk("rst_in_ready", 256'(in_ready), 256'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        wkey(0, ONES);
        chk("good_write_no_err", 256'(key_err), 256'd0);
        send(256'd1, {ONES[255:1], 1'b0}, 0, 1'b0);
        pulse_start();

        for (int r = 0; r <= 14; r++) wkey(r, kval(r));
        for (int i = 0; i < 16; i++) send('0, kval(i % 15), i % 15, 1'b0);

        pulse_start();
        wkey(15, PAT_X);
        chk("err_addr15", 256'(key_err), 256'd1);
        @(posedge clk); #1;
        chk("err_addr15_clr", 256'(key_err), 256'd0);
        send(PAT_P, PAT_P ^ kval(0), 0, 1'b0);
        wkey(3, PAT_X);
        chk("err_run_write", 256'(key_err), 256'd1);

        pulse_start();
        for (int r = 0; r < 5; r++) send(PAT_P, PAT_P ^ kval(r), r, 1'b0);
        send(PAT_P, PAT_P ^ kval(0), 0, 1'b1);
        send(PAT_P, PAT_P ^ kval(1), 1, 1'b0);

        pulse_start();
        key_we = 1'b1;
        key_addr = 4'd0;
        key_wdata = PAT_X;
        send(PAT_Q, PAT_Q, 0, 1'b0);
        key_we = 1'b0;
        chk("same_cycle_no_err", 256'(key_err), 256'd0);
        pulse_start();
        send(PAT_Q, PAT_Q ^ PAT_X, 0, 1'b0);

        pulse_start();
        out_ready = 1'b0;
        send(PAT_A, PAT_A ^ PAT_X, 0, 1'b0);
        in_valid = 1'b1;
        in_state = PAT_B;
        for (int k = 0; k < 3; k++) begin
            chk("stall_in_ready", 256'(in_ready), 256'd0);
            chk("stall_out_valid", 256'(out_valid), 256'd1);
            chk("stall_out_state", out_state, PAT_A ^ PAT_X);
            chk("stall_out_round", 256'(out_round), 256'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        e.st = PAT_B ^ kval(1);
        e.rnd = 4'd1;
        e.last = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;

        send(PAT_C, PAT_C ^ kval(2), 2, 1'b0);
        out_ready = 1'b0;
        chk("pre_rst_valid", 256'(out_valid), 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(out_valid), 256'd0);
        chk("mid_rst_state", out_state, 256'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(PAT_C, PAT_C, 0, 1'b0);
        send(PAT_D, PAT_D, 1, 1'b0);

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk("drain_empty", 256'(exp_q.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
